// File: rtl/flatten_pkg.sv
// flatten_pkg: shared state type and counter sizing for the flatten scheduler
package flatten_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  function automatic int cnt_w(input int m);
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/mod_counter.sv
// mod_counter: enabled modulo counter, wrap_o flags the enabled terminal count
module mod_counter import flatten_pkg::*; #(
  parameter int Modulus = 2
) (
  input  logic                      clk,
  input  logic                      res_n,
  input  logic                      en_i,
  output logic [cnt_w(Modulus)-1:0] cnt_o,
  output logic                      wrap_o
);
  localparam int W = cnt_w(Modulus);
  logic [W-1:0] cnt_q, cnt_d;
  assign wrap_o = en_i && cnt_q == W'(Modulus - 1);
  assign cnt_d  = wrap_o ? '0 : cnt_q + W'(en_i);
  assign cnt_o  = cnt_q;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/flatten_scheduler.sv
// flatten_scheduler: slices each accepted pixel group into NumOfInputs-wide slots
// for the flattening layer, then drains the layer with zero-data slots.
module flatten_scheduler import flatten_pkg::*; #(
  parameter int BitSize        = 4,
  parameter int ImageSize      = 4,
  parameter int NumOfImages    = 4,
  parameter int NumOfInputs    = 2,
  parameter int CyclesPerPixel = 2
) (
  input  logic                             clk,
  input  logic                             res_n,
  input  logic                             start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NumOfImages*BitSize-1:0]   in_data,
  output logic [NumOfImages-1:0]           fl_valid,
  output logic [NumOfInputs*BitSize-1:0]   fl_data,
  input  logic                             fl_out_valid,
  output logic                             fl_out_ready,
  input  logic                             ds_ready,
  output logic                             busy,
  output logic                             done
);
  localparam int GW = NumOfInputs * BitSize;
  localparam int SW = cnt_w(CyclesPerPixel);
  localparam int PW = cnt_w(ImageSize);

  if (CyclesPerPixel != NumOfImages / NumOfInputs || NumOfImages % NumOfInputs != 0) begin : g_bad_cfg
    $error("flatten_scheduler: CyclesPerPixel must equal NumOfImages/NumOfInputs");
  end

  state_t                       state_q, state_d;
  logic                         held_q, held_d;
  logic [NumOfImages*BitSize-1:0] data_q, data_d;
  logic                         done_q, done_d;
  logic [SW-1:0]                slot;
  logic [PW-1:0]                pix;
  logic                         stall, slot_en, slot_wrap, pix_wrap, slot_last, pix_last, accept;

  mod_counter #(.Modulus(CyclesPerPixel)) u_slot (
    .clk(clk), .res_n(res_n), .en_i(slot_en), .cnt_o(slot), .wrap_o(slot_wrap)
  );
  mod_counter #(.Modulus(ImageSize)) u_pix (
    .clk(clk), .res_n(res_n), .en_i(slot_wrap), .cnt_o(pix), .wrap_o(pix_wrap)
  );

  assign stall        = fl_out_valid && !ds_ready;
  assign fl_out_ready = ds_ready;
  assign slot_last    = slot == SW'(CyclesPerPixel - 1);
  assign pix_last     = pix == PW'(ImageSize - 1);
  assign slot_en      = !stall && (state_q == DRAIN || (state_q == ISSUE && held_q));
  // The final pixel's group must not overlap a new acceptance: nothing would ever issue it.
  assign in_ready     = state_q == ISSUE && !stall && (!held_q || (slot_last && !pix_last));
  assign accept       = in_valid && in_ready;
  assign busy         = state_q != IDLE;
  assign done         = done_q;
  assign fl_valid     = slot_en ? NumOfImages'({NumOfInputs{1'b1}}) << (NumOfInputs * int'(slot)) : '0;
  assign fl_data      = (state_q == ISSUE && held_q) ? data_q[int'(slot)*GW +: GW] : '0;

  always_comb begin
    state_d = state_q;
    held_d  = (state_q == ISSUE && slot_wrap) ? 1'b0 : held_q;
    data_d  = accept ? in_data : data_q;
    done_d  = pix_wrap && state_q == DRAIN;
    if (accept) held_d = 1'b1;
    if (state_q == IDLE && start && !done_q) state_d = ISSUE;
    if (pix_wrap) state_d = state_q == ISSUE ? DRAIN : IDLE;
  end

  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state_q <= IDLE;
      held_q  <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
endmodule
